// File: rtl/sa_wb_cache.sv
`default_nettype none
// ============================================================================
// Module  : sa_wb_cache
// Brief   : N-way set-associative write-back/write-allocate cache, true-LRU,
//           multi-word blocks, word-serial ready/ack memory port.
// Revision: 1.0 - initial release
// ============================================================================
module sa_wb_cache #(
    parameter int WIDTH       = 32,
    parameter int NWAYS       = 4,
    parameter int INDEX_WIDTH = 6,
    parameter int WORDS       = 4,
    parameter int TAG_WIDTH   = WIDTH - INDEX_WIDTH - $clog2(WORDS) - 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_din,
    output logic             cpu_ready,
    output logic             cpu_valid,
    output logic [WIDTH-1:0] cpu_q,
    output logic             cpu_hit,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_rden,
    output logic             mem_wren,
    output logic [WIDTH-1:0] mem_dout,
    input  logic [WIDTH-1:0] mem_q,
    input  logic             mem_ack
);
    localparam int c_nsets     = 2 ** INDEX_WIDTH;
    localparam int c_word_bits = $clog2(WORDS);
    localparam int c_way_bits  = $clog2(NWAYS);
    localparam int c_tag_lsb   = INDEX_WIDTH + c_word_bits + 2;
    localparam logic [INDEX_WIDTH-1:0] c_last_set  = INDEX_WIDTH'(c_nsets - 1);
    localparam logic [c_word_bits-1:0] c_last_beat = c_word_bits'(WORDS - 1);
    localparam logic [c_way_bits-1:0]  c_oldest    = c_way_bits'(NWAYS - 1);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_WBACK  = 3'd2,
        ST_REFILL = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    logic                   r_valid [NWAYS][c_nsets];
    logic                   r_dirty [NWAYS][c_nsets];
    logic [TAG_WIDTH-1:0]   r_tag   [NWAYS][c_nsets];
    logic [c_way_bits-1:0]  r_age   [NWAYS][c_nsets];
    logic [WIDTH-1:0]       r_data  [NWAYS][c_nsets][WORDS];

    state_t                 r_state, w_next_state;
    logic [INDEX_WIDTH-1:0] r_set_cnt;
    logic [c_word_bits-1:0] r_beat;
    logic [c_way_bits-1:0]  r_victim;
    logic                   r_req_we;
    logic [TAG_WIDTH-1:0]   r_req_tag;
    logic [INDEX_WIDTH-1:0] r_req_idx;
    logic [c_word_bits-1:0] r_req_word;
    logic [WIDTH-1:0]       r_req_din;

    logic [TAG_WIDTH-1:0]   w_tag;
    logic [INDEX_WIDTH-1:0] w_idx;
    logic [c_word_bits-1:0] w_word;
    logic                   w_hit, w_inv_any, w_accept, w_victim_dirty, w_last_beat;
    logic [c_way_bits-1:0]  w_hit_way, w_inv_way, w_lru_way, w_victim;
    logic [WIDTH-1:0]       w_hit_word;
    logic                   w_lru_en;
    logic [INDEX_WIDTH-1:0] w_lru_set;
    logic [c_way_bits-1:0]  w_lru_hit;
    logic                   w_unused;

    assign w_tag    = cpu_addr[WIDTH-1:c_tag_lsb];
    assign w_idx    = cpu_addr[c_tag_lsb-1:c_word_bits+2];
    assign w_word   = cpu_addr[c_word_bits+1:2];
    assign w_unused = ^cpu_addr[1:0];

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_inv_any = 1'b0;
        w_inv_way = '0;
        w_lru_way = '0;
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (!r_valid[w][w_idx]) begin
                w_inv_any = 1'b1;
                w_inv_way = c_way_bits'(w);
            end
            if (r_age[w][w_idx] == c_oldest) begin
                w_lru_way = c_way_bits'(w);
            end
            if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = c_way_bits'(w);
            end
        end
    end

    assign w_victim       = w_inv_any ? w_inv_way : w_lru_way;
    assign w_victim_dirty = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];
    assign w_hit_word     = r_data[w_hit_way][w_idx][w_word];
    assign w_last_beat    = (r_beat == c_last_beat);

    always_comb begin
        w_next_state = r_state;
        cpu_ready    = 1'b0;
        w_accept     = 1'b0;
        mem_rden     = 1'b0;
        mem_wren     = 1'b0;
        mem_addr     = '0;
        mem_dout     = '0;
        case (r_state)
            ST_INIT: begin
                if (r_set_cnt == c_last_set) w_next_state = ST_IDLE;
            end
            ST_IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) begin
                    w_accept = 1'b1;
                    if (!w_hit) w_next_state = w_victim_dirty ? ST_WBACK : ST_REFILL;
                end
            end
            ST_WBACK: begin
                mem_wren = 1'b1;
                mem_addr = {r_tag[r_victim][r_req_idx], r_req_idx, r_beat, 2'b00};
                mem_dout = r_data[r_victim][r_req_idx][r_beat];
                if (mem_ack && w_last_beat) w_next_state = ST_REFILL;
            end
            ST_REFILL: begin
                mem_rden = 1'b1;
                mem_addr = {r_req_tag, r_req_idx, r_beat, 2'b00};
                if (mem_ack && w_last_beat) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state    <= ST_INIT;
            r_set_cnt  <= '0;
            r_beat     <= '0;
            r_victim   <= '0;
            r_req_we   <= 1'b0;
            r_req_tag  <= '0;
            r_req_idx  <= '0;
            r_req_word <= '0;
            r_req_din  <= '0;
            cpu_valid  <= 1'b0;
            cpu_q      <= '0;
            cpu_hit    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            cpu_valid <= 1'b0;
            cpu_q     <= '0;
            cpu_hit   <= 1'b0;
            case (r_state)
                ST_INIT: r_set_cnt <= r_set_cnt + 1'b1;
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_we   <= cpu_we;
                        r_req_tag  <= w_tag;
                        r_req_idx  <= w_idx;
                        r_req_word <= w_word;
                        r_req_din  <= cpu_din;
                        r_beat     <= '0;
                        if (w_hit) begin
                            cpu_valid <= 1'b1;
                            cpu_hit   <= 1'b1;
                            cpu_q     <= cpu_we ? '0 : w_hit_word;
                        end else begin
                            r_victim <= w_victim;
                        end
                    end
                end
                ST_WBACK, ST_REFILL: begin
                    if (mem_ack) r_beat <= r_beat + 1'b1;
                end
                ST_DONE: begin
                    cpu_valid <= 1'b1;
                    cpu_q     <= r_req_we ? '0 : r_data[r_victim][r_req_idx][r_req_word];
                end
                default: ;
            endcase
        end
    end

    // Recency update is shared by hits (IDLE) and completed fills (DONE).
    assign w_lru_en  = (w_accept && w_hit) || (r_state == ST_DONE);
    assign w_lru_set = (r_state == ST_DONE) ? r_req_idx : w_idx;
    assign w_lru_hit = (r_state == ST_DONE) ? r_victim  : w_hit_way;

    // Array writes are suppressed while reset is sampled, dropping any pending ack.
    always_ff @(posedge clock) begin
        if (resetn) begin
            if (r_state == ST_INIT) begin
                for (int w = 0; w < NWAYS; w++) begin
                    r_valid[w][r_set_cnt] <= 1'b0;
                    r_dirty[w][r_set_cnt] <= 1'b0;
                    r_age[w][r_set_cnt]   <= c_way_bits'(w);
                end
            end
            if (w_lru_en) begin
                for (int w = 0; w < NWAYS; w++) begin
                    if (r_age[w][w_lru_set] < r_age[w_lru_hit][w_lru_set]) begin
                        r_age[w][w_lru_set] <= r_age[w][w_lru_set] + 1'b1;
                    end
                end
                r_age[w_lru_hit][w_lru_set] <= '0;
            end
            if (w_accept && w_hit && cpu_we) begin
                r_data[w_hit_way][w_idx][w_word] <= cpu_din;
                r_dirty[w_hit_way][w_idx]        <= 1'b1;
            end
            if ((r_state == ST_REFILL) && mem_ack) begin
                r_data[r_victim][r_req_idx][r_beat] <= mem_q;
                if (w_last_beat) begin
                    r_tag[r_victim][r_req_idx]   <= r_req_tag;
                    r_valid[r_victim][r_req_idx] <= 1'b1;
                    r_dirty[r_victim][r_req_idx] <= 1'b0;
                end
            end
            if ((r_state == ST_DONE) && r_req_we) begin
                r_data[r_victim][r_req_idx][r_req_word] <= r_req_din;
                r_dirty[r_victim][r_req_idx]            <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sa_wb_cache.sv
`default_nettype none
// ============================================================================
// Module  : tb_sa_wb_cache
// Brief   : Self-checking bench for sa_wb_cache against a recency-list model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sa_wb_cache;
    localparam int c_nways = 4;
    localparam int c_words = 4;
    localparam int c_nsets = 64;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_din = '0;
    logic        cpu_ready, cpu_valid, cpu_hit;
    logic [31:0] cpu_q;
    logic [31:0] mem_addr, mem_dout;
    logic        mem_rden, mem_wren;
    logic [31:0] mem_q;
    logic        mem_ack;

    int checks = 0;
    int fails  = 0;

    // Bench memory, architectural view and recency model
    logic [31:0] bmem [logic [31:0]];
    logic [31:0] arch [logic [31:0]];
    int unsigned recent [$];
    bit          dirty [int unsigned];
    beat_t       exp_beats [$];

    int          mem_delay = 0;
    int          wait_cnt = 0;
    int          stab_err = 0;
    int          both_err = 0;
    int          beat_mism = 0;
    int          rd_ack_cnt = 0;
    string       last_bad = "";
    logic [64:0] prev_req;

    logic        e_hit, o_hit;
    logic [31:0] e_q, o_q;
    int          e_lat, o_lat;

    sa_wb_cache dut (
        .clock     (clock),
        .resetn    (resetn),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_ready (cpu_ready),
        .cpu_valid (cpu_valid),
        .cpu_q     (cpu_q),
        .cpu_hit   (cpu_hit),
        .mem_addr  (mem_addr),
        .mem_rden  (mem_rden),
        .mem_wren  (mem_wren),
        .mem_dout  (mem_dout),
        .mem_q     (mem_q),
        .mem_ack   (mem_ack)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h0101_0101) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] rd_arch(input logic [31:0] a);
        return arch.exists(a) ? arch[a] : init_val(a);
    endfunction

    // Memory responder: acks each beat after mem_delay wait cycles and
    // scores every acked beat against the model's expected beat stream.
    initial begin
        beat_t eb;
        mem_ack = 1'b0;
        mem_q   = '0;
        forever begin
            @(posedge clock); #1;
            mem_ack = 1'b0;
            if (mem_rden && mem_wren) both_err++;
            if (mem_rden || mem_wren) begin
                if (wait_cnt > 0 && {mem_rden, mem_addr, mem_dout} !== prev_req) stab_err++;
                prev_req = {mem_rden, mem_addr, mem_dout};
                if (wait_cnt >= mem_delay) begin
                    wait_cnt = 0;
                    mem_ack  = 1'b1;
                    if (mem_wren) bmem[mem_addr] = mem_dout;
                    else begin
                        mem_q = rd_mem(mem_addr);
                        rd_ack_cnt++;
                    end
                    if (exp_beats.size() == 0) begin
                        beat_mism++;
                        last_bad = $sformatf("unexpected beat we=%0b addr=%h", mem_wren, mem_addr);
                    end else begin
                        eb = exp_beats.pop_front();
                        if (eb.we !== mem_wren || eb.addr !== mem_addr ||
                            (mem_wren && eb.data !== mem_dout)) begin
                            beat_mism++;
                            last_bad = $sformatf("beat we=%0b addr=%h data=%h, want we=%0b addr=%h data=%h",
                                                 mem_wren, mem_addr, mem_dout, eb.we, eb.addr, eb.data);
                        end
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Reference: a set holds the NWAYS most recent distinct lines mapping to it.
    task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] din);
        int unsigned line = addr >> 4;
        int unsigned set  = line % c_nsets;
        int          pos = -1, in_set = 0, lru_pos = -1;
        bit          dirty_ev = 0;
        int unsigned victim;
        logic [31:0] a = {addr[31:2], 2'b00};
        for (int i = 0; i < recent.size(); i++) begin
            if (recent[i] == line) pos = i;
            if (recent[i] % c_nsets == set) begin
                in_set++;
                lru_pos = i;
            end
        end
        e_q   = we ? 32'h0 : rd_arch(a);
        e_hit = (pos >= 0);
        if (pos >= 0) begin
            recent.delete(pos);
            e_lat = 1;
        end else begin
            if (in_set == c_nways) begin
                victim = recent[lru_pos];
                if (dirty.exists(victim)) begin
                    dirty_ev = 1;
                    for (int b = 0; b < c_words; b++)
                        exp_beats.push_back({1'b1, (victim << 4) + 32'(4 * b), rd_arch((victim << 4) + 32'(4 * b))});
                end
                recent.delete(lru_pos);
                dirty.delete(victim);
            end
            for (int b = 0; b < c_words; b++)
                exp_beats.push_back({1'b0, (line << 4) + 32'(4 * b), 32'h0});
            e_lat = (dirty_ev ? 2 : 1) * c_words * (mem_delay + 1) + 2;
        end
        recent.push_front(line);
        if (we) begin
            arch[a]     = din;
            dirty[line] = 1;
        end
    endtask

    task automatic model_reset();
        recent.delete();
        dirty.delete();
        arch.delete();
        foreach (bmem[k]) arch[k] = bmem[k];
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] din);
        int n = 0;
        model_access(we, addr, din);
        while (cpu_ready !== 1'b1 && n < 1000) begin
            @(posedge clock); #1;
            n++;
        end
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
        @(posedge clock); #1;
        cpu_req = 1'b0;
        o_lat = 1;
        while (cpu_valid !== 1'b1 && o_lat < 2000) begin
            @(posedge clock); #1;
            o_lat++;
        end
        o_hit = cpu_hit;
        o_q   = cpu_q;
        if (cpu_valid !== 1'b1) o_lat = -1;
    endtask

    task automatic test_reset();
        int n = 0;
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({cpu_ready, cpu_valid, cpu_hit, mem_rden, mem_wren, cpu_q, mem_addr, mem_dout} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: rdy=%b vld=%b hit=%b rd=%b wr=%b q=%h addr=%h dout=%h, want all 0",
                     cpu_ready, cpu_valid, cpu_hit, mem_rden, mem_wren, cpu_q, mem_addr, mem_dout);
        end
        resetn = 1'b1;
        model_reset();
        while (cpu_ready === 1'b0 && n < 200) begin
            n++;
            @(posedge clock); #1;
        end
        checks++;
        if (n != 64 || cpu_ready !== 1'b1) begin
            fails++;
            $display("FAIL init_length: ready low %0d cycles (ready=%b), want 64", n, cpu_ready);
        end
    endtask

    task automatic test_first_miss();
        access(1'b0, 32'h0000_0404, 32'h0);
        checks++;
        if ({o_hit, o_q, o_lat} !== {e_hit, e_q, e_lat} || o_hit !== 1'b0 || o_q !== init_val(32'h404)) begin
            fails++;
            $display("FAIL first_miss: hit/q/lat %b/%h/%0d, want %b/%h/%0d", o_hit, o_q, o_lat, 1'b0, init_val(32'h404), 6);
        end
        checks++;
        if (beat_mism !== 0 || exp_beats.size() != 0) begin
            fails++;
            $display("FAIL first_miss_beats: %0d bad, %0d missing, want 0/0; %s", beat_mism, exp_beats.size(), last_bad);
        end
    endtask

    task automatic test_hit();
        access(1'b0, 32'h0000_0404, 32'h0);
        checks++;
        if ({o_hit, o_q, o_lat} !== {e_hit, e_q, e_lat} || o_lat != 1) begin
            fails++;
            $display("FAIL load_hit: hit/q/lat %b/%h/%0d, want %b/%h/%0d", o_hit, o_q, o_lat, e_hit, e_q, e_lat);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            model_access(1'b0, 32'h400 + 32'(4 * i), 32'h0);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h400 + 32'(4 * i);
            @(posedge clock); #1;
            checks++;
            if (cpu_valid !== 1'b1 || cpu_hit !== 1'b1 || cpu_q !== e_q || cpu_ready !== 1'b1) begin
                fails++;
                $display("FAIL back_to_back[%0d]: vld=%b hit=%b q=%h rdy=%b, want 1/1/%h/1",
                         i, cpu_valid, cpu_hit, cpu_q, cpu_ready, e_q);
            end
        end
        cpu_req = 1'b0;
    endtask

    task automatic test_store_clean();
        access(1'b1, 32'h0000_0808, 32'hDEAD_BEEF);
        checks++;
        if ({o_hit, o_q, o_lat} !== {e_hit, e_q, e_lat}) begin
            fails++;
            $display("FAIL store_miss: hit/q/lat %b/%h/%0d, want %b/%h/%0d", o_hit, o_q, o_lat, e_hit, e_q, e_lat);
        end
        access(1'b0, 32'h0000_0808, 32'h0);
        checks++;
        if (o_hit !== 1'b1 || o_q !== 32'hDEAD_BEEF || o_lat != 1) begin
            fails++;
            $display("FAIL store_readback: hit/q/lat %b/%h/%0d, want 1/deadbeef/1", o_hit, o_q, o_lat);
        end
        checks++;
        if (beat_mism !== 0 || exp_beats.size() != 0) begin
            fails++;
            $display("FAIL store_beats: %0d bad, %0d missing, want 0/0; %s", beat_mism, exp_beats.size(), last_bad);
        end
    endtask

    task automatic test_eviction();
        logic [31:0] seq_addr [9] = '{32'h400, 32'h800, 32'hC00, 32'h1000, 32'h404,
                                      32'h800, 32'hC00, 32'h1000, 32'h1400};
        logic        seq_we   [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        for (int i = 0; i < 9; i++) begin
            access(seq_we[i], seq_addr[i], 32'hC0FF_EE01);
            checks++;
            if ({o_hit, o_q, o_lat} !== {e_hit, e_q, e_lat}) begin
                fails++;
                $display("FAIL evict_step[%0d]: hit/q/lat %b/%h/%0d, want %b/%h/%0d",
                         i, o_hit, o_q, o_lat, e_hit, e_q, e_lat);
            end
        end
        checks++;
        if (rd_mem(32'h404) !== 32'hC0FF_EE01 || o_lat != 2 * c_words + 2) begin
            fails++;
            $display("FAIL evict_writeback: mem[404]=%h lat=%0d, want c0ffee01 and %0d",
                     rd_mem(32'h404), o_lat, 2 * c_words + 2);
        end
        checks++;
        if (beat_mism !== 0 || exp_beats.size() != 0) begin
            fails++;
            $display("FAIL evict_beats: %0d bad, %0d missing, want 0/0; %s", beat_mism, exp_beats.size(), last_bad);
        end
    endtask

    task automatic test_delayed_ack();
        mem_delay = 3;
        access(1'b1, 32'h0000_1808, 32'h1234_5678);
        checks++;
        if ({o_hit, o_q, o_lat} !== {e_hit, e_q, e_lat}) begin
            fails++;
            $display("FAIL delayed_dirty: hit/q/lat %b/%h/%0d, want %b/%h/%0d", o_hit, o_q, o_lat, e_hit, e_q, e_lat);
        end
        access(1'b0, 32'h0000_2014, 32'h0);
        checks++;
        if ({o_hit, o_q, o_lat} !== {e_hit, e_q, e_lat} || o_lat != c_words * 4 + 2) begin
            fails++;
            $display("FAIL delayed_clean: hit/q/lat %b/%h/%0d, want %b/%h/%0d", o_hit, o_q, o_lat, e_hit, e_q, c_words * 4 + 2);
        end
        checks++;
        if (stab_err !== 0 || beat_mism !== 0 || exp_beats.size() != 0) begin
            fails++;
            $display("FAIL delayed_hold: unstable=%0d bad=%0d missing=%0d, want 0/0/0; %s",
                     stab_err, beat_mism, exp_beats.size(), last_bad);
        end
        mem_delay = 0;
    endtask

    task automatic test_random();
        int          bad = 0;
        logic [31:0] a;
        logic        we;
        for (int i = 0; i < 200; i++) begin
            mem_delay = $urandom_range(0, 2);
            a  = (32'($urandom_range(0, 7)) << 10) | (32'($urandom_range(0, 1)) << 4) |
                 (32'($urandom_range(0, 3)) << 2);
            we = 1'($urandom_range(0, 1));
            access(we, a, $urandom);
            checks++;
            if ({o_hit, o_q, o_lat} !== {e_hit, e_q, e_lat}) begin
                fails++;
                bad++;
                if (bad < 5)
                    $display("FAIL random[%0d] we=%b addr=%h: hit/q/lat %b/%h/%0d, want %b/%h/%0d",
                             i, we, a, o_hit, o_q, o_lat, e_hit, e_q, e_lat);
            end
        end
        mem_delay = 0;
        checks++;
        if (beat_mism !== 0 || exp_beats.size() != 0 || both_err !== 0 || stab_err !== 0) begin
            fails++;
            $display("FAIL random_beats: bad=%0d missing=%0d both=%0d unstable=%0d, want 0; %s",
                     beat_mism, exp_beats.size(), both_err, stab_err, last_bad);
        end
    endtask

    task automatic test_reset_midrefill();
        int n = 0;
        mem_delay = 0;
        model_access(1'b0, 32'h0000_2404, 32'h0);
        while (cpu_ready !== 1'b1 && n < 1000) begin
            @(posedge clock); #1;
            n++;
        end
        rd_ack_cnt = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h2404;
        @(posedge clock); #2;
        cpu_req = 1'b0;
        n = 0;
        while (rd_ack_cnt < 2 && n < 200) begin
            @(posedge clock); #2;
            n++;
        end
        resetn = 1'b0;
        @(posedge clock); #2;
        checks++;
        if (mem_rden !== 1'b0 || cpu_ready !== 1'b0 || cpu_valid !== 1'b0 || rd_ack_cnt != 2) begin
            fails++;
            $display("FAIL midrefill_reset: rden=%b rdy=%b vld=%b acks=%0d, want 0/0/0/2",
                     mem_rden, cpu_ready, cpu_valid, rd_ack_cnt);
        end
        resetn = 1'b1;
        exp_beats.delete();
        model_reset();
        n = 0;
        while (cpu_ready === 1'b0 && n < 200) begin
            n++;
            @(posedge clock); #1;
        end
        checks++;
        if (n != 64) begin
            fails++;
            $display("FAIL midrefill_init: ready low %0d cycles, want 64", n);
        end
        access(1'b0, 32'h0000_0404, 32'h0);
        checks++;
        if ({o_hit, o_q, o_lat} !== {e_hit, e_q, e_lat} || o_hit !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_miss: hit/q/lat %b/%h/%0d, want 0/%h/%0d", o_hit, o_q, o_lat, e_q, e_lat);
        end
        checks++;
        if (beat_mism !== 0 || exp_beats.size() != 0) begin
            fails++;
            $display("FAIL post_reset_beats: %0d bad, %0d missing, want 0/0; %s", beat_mism, exp_beats.size(), last_bad);
        end
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_hit();
        test_back_to_back();
        test_store_clean();
        test_eviction();
        test_delayed_ack();
        test_random();
        test_reset_midrefill();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sa_wb_cache.md
Name: sa_wb_cache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data/instruction cache with multi-word blocks.
- Successor of the 2-way single-word cache: generalises the way count and block size, adds true-LRU age counters and ready/valid CPU and memory handshakes, and gives a defined reset/flush sequence.
- Sits between the CPU load/store port and a word-serial memory port.

Parameters:
WIDTH, 32, data/address width in bits
NWAYS, 4, associativity (power of 2, 2..8)
INDEX_WIDTH, 6, log2(number of sets); NSETS = 2**INDEX_WIDTH
WORDS, 4, words per block (power of 2, >=2); WORD_BITS = log2(WORDS)
TAG_WIDTH, WIDTH-INDEX_WIDTH-WORD_BITS-2, tag bits

Ports:
clock  in  1  system clock, all logic on rising edge
resetn  in  1  synchronous active-low reset
cpu_req  in  1  request strobe, accepted when cpu_req && cpu_ready
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  WIDTH  byte address; [1:0] ignored
cpu_din  in  WIDTH  store data
cpu_ready  out  1  cache can accept a request this cycle
cpu_valid  out  1  one-cycle pulse: request complete
cpu_q  out  WIDTH  load data, valid with cpu_valid (0 for stores)
cpu_hit  out  1  with cpu_valid: 1 = hit, 0 = serviced via miss
mem_addr  out  WIDTH  word byte-address of current memory beat
mem_rden  out  1  memory read beat request
mem_wren  out  1  memory write beat request
mem_dout  out  WIDTH  write-back data
mem_q  in  WIDTH  read data, valid with mem_ack
mem_ack  in  1  beat complete (read data valid / write accepted)

Behaviour:
- Address split: tag=[WIDTH-1:INDEX_WIDTH+WORD_BITS+2], index=[INDEX_WIDTH+WORD_BITS+1:WORD_BITS+2], word=[WORD_BITS+1:2].
- Per way per set: valid, dirty, tag, WORDS data words, age (log2 NWAYS bits).
- States: INIT, IDLE, WBACK, REFILL, DONE.
- Reset (resetn=0 sampled at edge, from any state): state<=INIT, set counter<=0, cpu_ready=0, cpu_valid=0, cpu_q=0, cpu_hit=0, mem_rden=0, mem_wren=0, mem_addr=0, mem_dout=0. Any in-flight miss is abandoned; a pending mem_ack is ignored.
- INIT: one set per cycle, clear valid/dirty of all ways and set age[w]=w. After NSETS cycles go to IDLE. cpu_ready=0 throughout.
- IDLE: cpu_ready=1. On accept, request fields are latched and tags compared.
  - Hit in way h: next cycle cpu_valid=1, cpu_hit=1. Load: cpu_q=word. Store: word<=cpu_din, dirty=1, cpu_q=0. Total latency 1 cycle; a new request can be accepted that same cycle (back-to-back hits, 1 per cycle).
- LRU update on every hit or fill of way h: ways with age < age[h] increment; age[h]<=0. Ages always form a permutation of 0..NWAYS-1.
- Miss victim selection: lowest-index invalid way; otherwise the way with age NWAYS-1.
  - Victim valid and dirty: go to WBACK.
  - Otherwise: go to REFILL.
  - cpu_ready=0 from the miss cycle until DONE.
- WBACK: beats b=0..WORDS-1. mem_wren=1, mem_addr={victim tag, index, b, 2'b00}, mem_dout=word b. Signals are held until mem_ack; advance on mem_ack. After the last ack, mem_wren=0 and go to REFILL.
- REFILL: beats b=0..WORDS-1 in ascending order. mem_rden=1, mem_addr={req tag, index, b, 2'b00}, held until mem_ack; mem_q is written to victim word b on ack. After the last ack: tag written, valid=1, dirty=0, mem_rden=0, go to DONE.
- mem_rden and mem_wren are never both 1.
- DONE: apply the request to the filled line: a store writes and sets dirty; a load returns the word. Pulse cpu_valid=1, cpu_hit=0; LRU updated; go to IDLE.
- Miss latency with zero-wait memory: 2*WORDS+2 cycles if dirty, WORDS+2 if clean.
- cpu_req while cpu_ready=0 is ignored (requester must hold).
- mem_ack while neither mem_rden nor mem_wren is asserted is ignored.

Test Plan:
- Reset then wait: cpu_ready=0 for exactly 64 cycles, then 1; load 0x0000_0404 misses -> 4 read beats at 0x400,0x404,0x408,0x40C; cpu_valid with cpu_hit=0 and cpu_q=memory[0x404].
- Load 0x0000_0404 again -> cpu_valid 1 cycle after accept, cpu_hit=1, same data; 4 back-to-back hits to 0x400..0x40C -> 4 consecutive cpu_valid pulses.
- Store 0xDEADBEEF to 0x0808 (set 0 miss, clean refill), then load 0x0808 -> hit returning 0xDEADBEEF; no mem_wren asserted.
- Fill set 0 with tags 1..4 (0x400,0x800,0xC00,0x1000), store to tag 1, touch tags 2,3,4, then access 0x1400 -> tag 1 line evicted: 4 write beats at 0x400.. carrying the stored data, followed by refill at 0x1400.
- Memory ack delayed 3 cycles per beat -> mem_addr, mem_rden and mem_dout held stable until ack; completion cycle count matches.
- resetn=0 during 2nd refill beat -> mem_rden=0 next cycle, INIT restarts; after INIT, load 0x0404 misses again.
